// File: rtl/msrv32_lsu_bus_master.sv
// msrv32_lsu_bus_master: stage-3 load/store unit driving a req/ack data bus.
// Stores are lane-replicated with a byte mask; loads are lane-extracted and extended.
module msrv32_lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        mem_op_valid_in,
  input  logic        mem_we_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] dm_rdata_in,
  input  logic        dm_ack_in,
  output logic        dm_req_out,
  output logic        dm_we_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_mask_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        stall_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic uns_q, uns_d, we_q, we_d;
  logic req_q, req_d, ld_valid_q, ld_valid_d, misal_q, misal_d, berr_q, berr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0] mask_q, mask_d;
  logic misal, timeout, start, done;
  logic [31:0] wdata_fmt, rsh, ext;
  logic [3:0] mask_fmt;
  logic [7:0] byte_l;
  logic [15:0] half_l;
  assign misal   = (load_size_in == 2'd1 && addr_in[0]) || (load_size_in[1] && addr_in[1:0] != 2'd0);
  assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign start   = state_q == IDLE && mem_op_valid_in && !misal;
  assign done    = state_q == REQ && (dm_ack_in || timeout);
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= '0;
      off_q      <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      ld_valid_q <= 1'b0;
      misal_q    <= 1'b0;
      berr_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ldata_q    <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      off_q      <= off_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      req_q      <= req_d;
      ld_valid_q <= ld_valid_d;
      misal_q    <= misal_d;
      berr_q     <= berr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ldata_q    <= ldata_d;
      mask_q     <= mask_d;
    end
  end
  // ack wins over the timeout when both land on the last REQ cycle
  always_comb begin
    state_d = state_q == IDLE ? (mem_op_valid_in ? (misal ? RESP : REQ) : IDLE)
            : state_q == REQ  ? ((dm_ack_in || timeout) ? RESP : REQ)
            : IDLE;
  end
  always_comb begin
    wdata_fmt = load_size_in == 2'd0 ? {4{store_data_in[7:0]}}
              : load_size_in == 2'd1 ? {2{store_data_in[15:0]}}
              : store_data_in;
    mask_fmt  = load_size_in == 2'd0 ? 4'b0001 << addr_in[1:0]
              : load_size_in == 2'd1 ? (addr_in[1] ? 4'b1100 : 4'b0011)
              : 4'b1111;
    rsh       = dm_rdata_in >> {off_q, 3'b000};
    byte_l    = rsh[7:0];
    half_l    = off_q[1] ? dm_rdata_in[31:16] : dm_rdata_in[15:0];
    ext       = size_q == 2'd0 ? {{24{~uns_q & byte_l[7]}}, byte_l}
              : size_q == 2'd1 ? {{16{~uns_q & half_l[15]}}, half_l}
              : dm_rdata_in;
    cnt_d      = state_q == REQ ? cnt_q + CNT_W'(1) : '0;
    size_d     = start ? load_size_in : size_q;
    off_d      = start ? addr_in[1:0] : off_q;
    uns_d      = start ? load_unsigned_in : uns_q;
    we_d       = start ? mem_we_in : we_q;
    req_d      = state_d == REQ;
    addr_d     = start ? {addr_in[31:2], 2'b00} : addr_q;
    wdata_d    = start ? (mem_we_in ? wdata_fmt : 32'd0) : wdata_q;
    mask_d     = start ? (mem_we_in ? mask_fmt : 4'b1111) : mask_q;
    ld_valid_d = done && dm_ack_in && !we_q;
    misal_d    = state_q == IDLE && mem_op_valid_in && misal;
    berr_d     = done && !dm_ack_in;
    ldata_d    = ld_valid_d ? ext : berr_d ? 32'd0 : ldata_q;
  end
  assign dm_req_out     = req_q;
  assign dm_we_out      = we_q;
  assign dm_addr_out    = addr_q;
  assign dm_wdata_out   = wdata_q;
  assign dm_mask_out    = mask_q;
  assign load_data_out  = ldata_q;
  assign load_valid_out = ld_valid_q;
  assign misaligned_out = misal_q;
  assign bus_err_out    = berr_q;
  assign stall_out      = (state_q == IDLE && mem_op_valid_in) || state_q == REQ;
endmodule

// File: tb/tb_msrv32_lsu_bus_master.sv
// tb_msrv32_lsu_bus_master: directed and random transactions against a cycle-level reference model.
module tb_msrv32_lsu_bus_master;
  logic clk_in = 1'b0, reset_in = 1'b0;
  logic mem_op_valid_in = 1'b0, mem_we_in = 1'b0, load_unsigned_in = 1'b0, dm_ack_in = 1'b0;
  logic [1:0] load_size_in = '0;
  logic [31:0] addr_in = '0, store_data_in = '0, dm_rdata_in = '0;
  logic dm_req_out, dm_we_out, load_valid_out, misaligned_out, bus_err_out, stall_out;
  logic [31:0] dm_addr_out, dm_wdata_out, load_data_out;
  logic [3:0] dm_mask_out;
  int total = 0, bad = 0;
  logic [31:0] exp_ld = '0;

  msrv32_lsu_bus_master dut (
    .clk_in(clk_in), .reset_in(reset_in), .mem_op_valid_in(mem_op_valid_in), .mem_we_in(mem_we_in),
    .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in), .addr_in(addr_in),
    .store_data_in(store_data_in), .dm_rdata_in(dm_rdata_in), .dm_ack_in(dm_ack_in),
    .dm_req_out(dm_req_out), .dm_we_out(dm_we_out), .dm_addr_out(dm_addr_out),
    .dm_wdata_out(dm_wdata_out), .dm_mask_out(dm_mask_out), .load_data_out(load_data_out),
    .load_valid_out(load_valid_out), .misaligned_out(misaligned_out), .bus_err_out(bus_err_out),
    .stall_out(stall_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input logic lv, input logic mis, input logic be);
    chk({tag, "_load_valid"}, 32'(load_valid_out), 32'(lv));
    chk({tag, "_misaligned"}, 32'(misaligned_out), 32'(mis));
    chk({tag, "_bus_err"}, 32'(bus_err_out), 32'(be));
  endtask

  // One full instruction: dly = number of REQ cycles before ack (>=16 never acks).
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd, input int dly);
    logic mis, acked;
    logic [31:0] ew, lane;
    logic [3:0] em;
    int off;
    off = int'(a[1:0]);
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    if (!we) begin
      ew = 0;
      em = 4'hF;
    end else if (sz == 2'd0) begin
      ew = (sd & 32'hFF) * 32'h0101_0101;
      em = 4'(1 << off);
    end else if (sz == 2'd1) begin
      ew = (sd & 32'hFFFF) * 32'h0001_0001;
      em = 4'(3 << (2 * (off / 2)));
    end else begin
      ew = sd;
      em = 4'hF;
    end
    if (sz == 2'd0) begin
      lane = (rd >> (8 * off)) & 32'hFF;
      if (!uns && lane >= 32'h80) lane = lane + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      lane = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && lane >= 32'h8000) lane = lane + 32'hFFFF_0000;
    end else lane = rd;
    mem_op_valid_in = 1'b1;
    mem_we_in = we;
    load_size_in = sz;
    load_unsigned_in = uns;
    addr_in = a;
    store_data_in = sd;
    dm_ack_in = 1'b0;
    @(negedge clk_in);
    chk("idle_stall", 32'(stall_out), 32'd1);
    chk("idle_req", 32'(dm_req_out), 32'd0);
    tick;
    acked = 1'b0;
    if (!mis) begin
      for (int i = 0; i < 16; i++) begin
        acked = (i == dly);
        dm_ack_in = acked;
        dm_rdata_in = acked ? rd : $urandom;
        @(negedge clk_in);
        chk("req_req", 32'(dm_req_out), 32'd1);
        chk("req_stall", 32'(stall_out), 32'd1);
        chk("req_we", 32'(dm_we_out), 32'(we));
        chk("req_addr", dm_addr_out, a & 32'hFFFF_FFFC);
        chk("req_wdata", dm_wdata_out, ew);
        chk("req_mask", 32'(dm_mask_out), 32'(em));
        chk_pulses("req", 1'b0, 1'b0, 1'b0);
        tick;
        if (acked) break;
      end
      if (acked && !we) exp_ld = lane;
      else if (!acked) exp_ld = 0;
    end
    dm_ack_in = 1'($urandom_range(0, 1));
    dm_rdata_in = $urandom;
    @(negedge clk_in);
    chk("resp_req", 32'(dm_req_out), 32'd0);
    chk("resp_stall", 32'(stall_out), 32'd0);
    chk_pulses("resp", !mis && acked && !we, mis, !mis && !acked);
    chk("resp_load_data", load_data_out, exp_ld);
    tick;
    mem_op_valid_in = 1'b0;
    dm_ack_in = 1'b0;
    @(negedge clk_in);
    chk("after_stall", 32'(stall_out), 32'd0);
    chk("after_req", 32'(dm_req_out), 32'd0);
    chk_pulses("after", 1'b0, 1'b0, 1'b0);
    chk("after_load_data", load_data_out, exp_ld);
    tick;
  endtask

  initial begin
    #12;
    chk("rst_req", 32'(dm_req_out), 32'd0);
    chk("rst_addr", dm_addr_out, 32'd0);
    chk("rst_wdata", dm_wdata_out, 32'd0);
    chk("rst_mask", 32'(dm_mask_out), 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b1;
    tick;
    txn(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2);
    chk("word_load", load_data_out, 32'hDEAD_BEEF);
    txn(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1);
    chk("sbyte_load", load_data_out, 32'hFFFF_FF80);
    txn(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    chk("ubyte_load", load_data_out, 32'h0000_0080);
    txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0);
    txn(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 99);
    chk("timeout_load_data", load_data_out, 32'd0);
    txn(1'b0, 2'd1, 1'b0, 32'h0000_5002, 32'h0, 32'h9ABC_1234, 15);
    chk("ack_on_last", load_data_out, 32'hFFFF_9ABC);
    for (int n = 0; n < 40; n++)
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom, int'($urandom_range(0, 18)));
    mem_op_valid_in = 1'b1;
    mem_we_in = 1'b0;
    load_size_in = 2'd2;
    addr_in = 32'h0000_6000;
    tick;
    tick;
    #2;
    reset_in = 1'b0;
    mem_op_valid_in = 1'b0;
    #1;
    chk("midrst_req", 32'(dm_req_out), 32'd0);
    chk("midrst_stall", 32'(stall_out), 32'd0);
    chk("midrst_load_data", load_data_out, 32'd0);
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      @(negedge clk_in);
      chk("postrst_req", 32'(dm_req_out), 32'd0);
      chk("postrst_stall", 32'(stall_out), 32'd0);
      chk_pulses("postrst", 1'b0, 1'b0, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/msrv32_lsu_bus_master.md
Name: msrv32_lsu_bus_master

Overview:
- Stage-3 consumer of the decode/execute pipeline register outputs: iadder address, rs2 store data, load_size, load_unsigned, memory-op strobe.
- Performs one data-memory transaction per instruction over a req/ack bus, formats store data and byte mask, aligns and extends load data.
- Holds the pipeline with stall_out until the transaction completes, faults or times out.

Parameters:
- TIMEOUT_CYCLES, 16: maximum REQ-state cycles without ack before a bus error; minimum 2.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk_in  input  1  clock, rising edge.
- reset_in  input  1  asynchronous active-low reset.
- mem_op_valid_in  input  1  stage-3 instruction is a load or store.
- mem_we_in  input  1  1=store, 0=load.
- load_size_in  input  2  access size: 00=byte, 01=half, 10=word, 11=word.
- load_unsigned_in  input  1  zero-extend loads when 1, sign-extend when 0.
- addr_in  input  32  effective address (iadder).
- store_data_in  input  32  rs2 value.
- dm_rdata_in  input  32  bus read data, valid with dm_ack_in.
- dm_ack_in  input  1  bus completion strobe.
- dm_req_out  output  1  bus request, registered.
- dm_we_out  output  1  bus write enable, registered.
- dm_addr_out  output  32  word-aligned bus address, registered.
- dm_wdata_out  output  32  lane-replicated store data, registered.
- dm_mask_out  output  4  byte-enable mask, registered.
- load_data_out  output  32  aligned and extended load result.
- load_valid_out  output  1  one-cycle pulse, successful load completion.
- misaligned_out  output  1  one-cycle pulse, alignment fault.
- bus_err_out  output  1  one-cycle pulse, timeout fault.
- stall_out  output  1  combinational pipeline hold.

Behaviour:
- Reset (reset_in=0, asynchronous): state=IDLE, counter=0, all registered outputs 0. An in-flight request is dropped immediately. No retry after reset.
- States: IDLE, REQ, RESP.
- IDLE:
  - mem_op_valid_in=1 with a misaligned access goes to RESP with misaligned_out=1 and no bus request. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise, on the next edge: capture size, unsigned, addr[1:0] and we; set dm_req_out=1, dm_we_out=mem_we_in, dm_addr_out={addr[31:2],2'b00}; go to REQ with counter=0.
- Store formatting:
  - byte: wdata={4{d[7:0]}}, mask=0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, mask=0011<<(2*addr[1]).
  - word: wdata=d, mask=1111.
  - Loads drive mask=1111 and wdata=0.
- REQ:
  - All bus outputs are held stable.
  - dm_ack_in=1: dm_req_out drops at this edge. For a load, register load_data_out and pulse load_valid_out in RESP. Go to RESP.
  - No ack and counter==TIMEOUT_CYCLES-1: dm_req_out drops, load_data_out=0, bus_err_out pulses in RESP, go to RESP.
  - Otherwise counter+1.
  - Ack on the timeout cycle counts as success (ack has priority).
- Load extraction:
  - byte: lane dm_rdata_in[8k+7:8k], k=addr[1:0].
  - half: lane dm_rdata_in[16j+15:16j], j=addr[1].
  - Extension: upper bits = sign bit of the lane, or 0 if load_unsigned.
- RESP: lasts exactly 1 cycle, then IDLE. Pulse outputs are 1 only in RESP. load_data_out holds its value until the next load completion or reset.
- stall_out = (IDLE && mem_op_valid_in) || REQ. It is 0 in RESP, so the pipeline advances at the edge ending RESP. mem_op_valid_in is ignored during RESP.
- dm_ack_in outside REQ is ignored.
- Store completion raises no pulse. The only visible effect is stall_out releasing.

Test Plan:
- Word load, addr=0x0000_1004, ack after 2 REQ cycles, rdata=0xDEAD_BEEF -> dm_addr_out=0x1004, mask=1111, stall high 4 cycles, load_valid pulse, load_data_out=0xDEAD_BEEF.
- Signed byte load, addr=0x1003, rdata=0x80FF_0000 -> load_data_out=0xFFFF_FF80. Repeated with load_unsigned=1 -> 0x0000_0080.
- Half store, addr=0x2002, store_data=0x1234_ABCD, immediate ack -> dm_wdata_out=0xABCD_ABCD, dm_mask_out=1100, dm_we_out=1, no load_valid pulse.
- Word load at addr=0x3001 -> no dm_req_out, misaligned_out pulse after 1 cycle, stall_out high exactly 1 cycle.
- Load with ack never asserted, TIMEOUT_CYCLES=16 -> dm_req_out high 16 cycles, then bus_err_out pulse, load_data_out=0, IDLE.
- reset_in low mid-REQ -> dm_req_out and stall_out 0 immediately. After release with mem_op_valid_in=0 the block stays IDLE with no request.
